// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a one-word holding register, so that
// back-to-back words leave as one continuous bit stream.
module piso_serializer #(
  parameter int   DATA_WIDTH    = 8,
  parameter logic MSB_FIRST     = 1'b0,
  parameter logic INIT          = 1'b0,
  parameter logic IS_C_INVERTED = 1'b0
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  CE,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  LOAD_VLD,
  output logic                  LOAD_RDY,
  output logic                  Q,
  output logic                  LAST,
  output logic                  BUSY
);

  // Handshake: a word moves from D into the holding register on an active
  // edge where LOAD_VLD=1 and LOAD_RDY=1; LOAD_RDY depends only on state.

  localparam int              CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_SHIFT = 1'b1;

  // Falling-edge operation is folded into a single internal clock.
  logic clk;
  assign clk = C ^ IS_C_INVERTED;

  logic [0:0]            state     = ST_IDLE;
  logic [DATA_WIDTH-1:0] hold      = '0;
  logic                  hold_full = 1'b0;
  logic [DATA_WIDTH-1:0] sr        = '0;
  logic [CW-1:0]         cnt       = '0;
  logic                  q_r       = INIT;
  logic                  last_r    = 1'b0;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // Remaining bits move toward the output end; vacated positions fill with 0.
  function automatic logic [DATA_WIDTH-1:0] rest_bits(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (R) begin
      state     <= ST_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      q_r       <= INIT;
      last_r    <= 1'b0;
    end else begin
      if (LOAD_VLD && !hold_full) begin
        hold      <= D;
        hold_full <= 1'b1;
      end
      // The drain below only fires with hold_full=1, so it never meets an accept.
      if (CE) begin
        if (state == ST_SHIFT && cnt != CNT_FULL) begin
          q_r    <= first_bit(sr);
          sr     <= rest_bits(sr);
          cnt    <= cnt + CW'(1);
          last_r <= (cnt + CW'(1)) == CNT_FULL;
        end else if (hold_full) begin
          q_r       <= first_bit(hold);
          sr        <= rest_bits(hold);
          hold_full <= 1'b0;
          cnt       <= CW'(1);
          state     <= ST_SHIFT;
          last_r    <= 1'b0;
        end else begin
          q_r    <= INIT;
          last_r <= 1'b0;
          cnt    <= '0;
          state  <= ST_IDLE;
        end
      end
    end
  end

  assign LOAD_RDY = ~hold_full;
  assign Q        = q_r;
  assign LAST     = last_r;
  assign BUSY     = (state == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (LSB-first, MSB-first with INIT=1,
// falling-edge clock) checked against a bit-queue model plus directed vectors.
module tb_piso_serializer;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       CE = 1'b0;
  logic       LOAD_VLD = 1'b0;
  logic [7:0] D = '0;
  logic [2:0] rdy_o, q_o, last_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 C = ~C;

  piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .INIT(1'b0), .IS_C_INVERTED(1'b0)) u_lsb (
    .C(C), .R(R), .CE(CE), .D(D), .LOAD_VLD(LOAD_VLD),
    .LOAD_RDY(rdy_o[0]), .Q(q_o[0]), .LAST(last_o[0]), .BUSY(busy_o[0]));

  piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .INIT(1'b1), .IS_C_INVERTED(1'b0)) u_msb (
    .C(C), .R(R), .CE(CE), .D(D), .LOAD_VLD(LOAD_VLD),
    .LOAD_RDY(rdy_o[1]), .Q(q_o[1]), .LAST(last_o[1]), .BUSY(busy_o[1]));

  piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .INIT(1'b0), .IS_C_INVERTED(1'b1)) u_inv (
    .C(C), .R(R), .CE(CE), .D(D), .LOAD_VLD(LOAD_VLD),
    .LOAD_RDY(rdy_o[2]), .Q(q_o[2]), .LAST(last_o[2]), .BUSY(busy_o[2]));

  // Reference model: a pending-word slot and a queue of bits still to leave.
  logic       m_hold_v[3];
  logic [7:0] m_hold_w[3];
  bit         m_rem[3][$];
  logic       m_q[3], m_last[3], m_busy[3];

  function automatic logic msb_of(input int m);
    return m == 1;
  endfunction

  function automatic logic init_of(input int m);
    return m == 1;
  endfunction

  task automatic model_reset(input int m);
    m_hold_v[m] = 1'b0;
    m_hold_w[m] = '0;
    m_rem[m].delete();
    m_q[m]    = init_of(m);
    m_last[m] = 1'b0;
    m_busy[m] = 1'b0;
  endtask

  task automatic model_step(input int m, input logic r, input logic ce,
                            input logic vld, input logic [7:0] d);
    logic acc;
    if (r) begin
      model_reset(m);
      return;
    end
    acc = vld && !m_hold_v[m];
    if (ce) begin
      if (m_rem[m].size() > 0) begin
        m_q[m]    = m_rem[m].pop_front();
        m_last[m] = (m_rem[m].size() == 0);
        m_busy[m] = 1'b1;
      end else if (m_hold_v[m]) begin
        for (int i = 0; i < 8; i++)
          m_rem[m].push_back(msb_of(m) ? m_hold_w[m][7-i] : m_hold_w[m][i]);
        m_hold_v[m] = 1'b0;
        m_q[m]    = m_rem[m].pop_front();
        m_last[m] = 1'b0;
        m_busy[m] = 1'b1;
      end else begin
        m_q[m]    = init_of(m);
        m_last[m] = 1'b0;
        m_busy[m] = 1'b0;
      end
    end
    if (acc) begin
      m_hold_v[m] = 1'b1;
      m_hold_w[m] = d;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic compare_model(input int m);
    check($sformatf("dut%0d_q", m),    q_o[m],    m_q[m]);
    check($sformatf("dut%0d_last", m), last_o[m], m_last[m]);
    check($sformatf("dut%0d_busy", m), busy_o[m], m_busy[m]);
    check($sformatf("dut%0d_rdy", m),  rdy_o[m],  !m_hold_v[m]);
  endtask

  // One clock period: the inverted instance sees these inputs on the negedge,
  // the other two on the following posedge.
  task automatic cycle(input logic r, input logic ce, input logic vld, input logic [7:0] d);
    R = r; CE = ce; LOAD_VLD = vld; D = d;
    @(negedge C); #1;
    model_step(2, r, ce, vld, d);
    compare_model(2);
    @(posedge C); #1;
    model_step(0, r, ce, vld, d);
    model_step(1, r, ce, vld, d);
    compare_model(0);
    compare_model(1);
    check("inv_q_across_posedge", q_o[2], m_q[2]);
  endtask

  typedef struct {
    logic       r, ce, vld;
    logic [7:0] d;
    logic       q, last, busy, rdy;
  } vec_t;

  vec_t       tbl[11];
  logic [15:0] exp_stream;
  logic       prev_q;

  initial begin
    // Single LSB-first word 0xA5: bits 1,0,1,0,0,1,0,1 with LAST on the 8th.
    tbl[0]  = '{r:1, ce:1, vld:0, d:8'h00, q:0, last:0, busy:0, rdy:1};
    tbl[1]  = '{r:0, ce:1, vld:1, d:8'hA5, q:0, last:0, busy:0, rdy:0};
    tbl[2]  = '{r:0, ce:1, vld:0, d:8'h00, q:1, last:0, busy:1, rdy:1};
    tbl[3]  = '{r:0, ce:1, vld:0, d:8'h00, q:0, last:0, busy:1, rdy:1};
    tbl[4]  = '{r:0, ce:1, vld:0, d:8'h00, q:1, last:0, busy:1, rdy:1};
    tbl[5]  = '{r:0, ce:1, vld:0, d:8'h00, q:0, last:0, busy:1, rdy:1};
    tbl[6]  = '{r:0, ce:1, vld:0, d:8'h00, q:0, last:0, busy:1, rdy:1};
    tbl[7]  = '{r:0, ce:1, vld:0, d:8'h00, q:1, last:0, busy:1, rdy:1};
    tbl[8]  = '{r:0, ce:1, vld:0, d:8'h00, q:0, last:0, busy:1, rdy:1};
    tbl[9]  = '{r:0, ce:1, vld:0, d:8'h00, q:1, last:1, busy:1, rdy:1};
    tbl[10] = '{r:0, ce:1, vld:0, d:8'h00, q:0, last:0, busy:0, rdy:1};

    for (int m = 0; m < 3; m++) model_reset(m);
    @(posedge C); #1;

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, tbl[i].ce, tbl[i].vld, tbl[i].d);
      check($sformatf("tbl%0d_q", i),    q_o[0],    tbl[i].q);
      check($sformatf("tbl%0d_last", i), last_o[0], tbl[i].last);
      check($sformatf("tbl%0d_busy", i), busy_o[0], tbl[i].busy);
      check($sformatf("tbl%0d_rdy", i),  rdy_o[0],  tbl[i].rdy);
    end

    // Back-to-back 0x01 then 0xFF: 16 contiguous bits, no INIT gap.
    cycle(1, 1, 0, 8'h00);
    cycle(0, 1, 1, 8'h01);
    check("b2b_rdy_after_accept", rdy_o[0], 1'b0);
    exp_stream = 16'hFF01;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, (i < 2), 8'hFF);
      check($sformatf("b2b_bit%0d", i), q_o[0], exp_stream[i]);
      check($sformatf("b2b_busy%0d", i), busy_o[0], 1'b1);
    end
    cycle(0, 1, 0, 8'h00);
    check("b2b_idle_q", q_o[0], 1'b0);
    check("b2b_idle_busy", busy_o[0], 1'b0);

    // Reset mid-word: remaining bits of 0xA5 must never appear.
    cycle(0, 1, 1, 8'hA5);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00);
    cycle(1, 1, 1, 8'hFF);
    cycle(1, 0, 1, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 8'h00);
      check($sformatf("rst_q%0d", i), q_o[0], 1'b0);
      check($sformatf("rst_busy%0d", i), busy_o[0], 1'b0);
      check($sformatf("rst_last%0d", i), last_o[0], 1'b0);
      check($sformatf("rst_rdy%0d", i), rdy_o[0], 1'b1);
      check($sformatf("rst_msb_q%0d", i), q_o[1], 1'b1);
    end

    // CE gating on 0x3C, with a word accepted while CE is low.
    cycle(0, 1, 1, 8'h3C);
    cycle(0, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      prev_q = m_q[0];
      if (i % 3 == 0) begin
        cycle(0, 1, 0, 8'h00);
      end else begin
        cycle(0, 0, (i == 1), 8'h81);
        check($sformatf("ce_frozen_q%0d", i), q_o[0], prev_q);
        if (i == 1) check("ce_low_accept", rdy_o[0], 1'b0);
      end
    end
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 8'h00);
    check("ce_drained_busy", busy_o[0], 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
